sasa_block_engine: RTL and testbench

Parametrised controller for sparse attention softmax approximation (SASA) over block-diagonal QK tiles. It fetches `cfg_nblk` diagonal blocks of `BLK`×`BLK` scores from the score memory into a local tile buffer. For each block it then streams the tile to CAM1 for find-max, issues the max-subtract vector, and rounds/prunes the CAM1 results toward the MVU. It waits for CAM2 completion before advancing to the next block. It sits between the score memory and the CAM1/MVU/CAM2 datapath, and is started per attention head by the top-level sequencer.

---
 rtl/sasa_pkg.sv | 13 +
 rtl/sasa_round.sv | 31 +++
 rtl/sasa_block_engine.sv | 115 +++++++++++
 tb/tb_sasa_block_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sasa_pkg.sv
// sasa_pkg: shared states, default parameters and sizing helper for the SASA block engine
package sasa_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, FMAX, MWAIT, SUB, NORM, WB, DONE} sasa_state_e;
    localparam int SASA_DATA_W   = 32;
    localparam int SASA_BLK      = 4;
    localparam int SASA_MAX_NBLK = 8;
    localparam int SASA_ADDR_W   = 6;
    localparam int SASA_FRAC     = 4;
    localparam int SASA_PRUNE_TH = -100;
    function automatic int tile_idx_w(input int blk);
        return blk * blk > 1 ? $clog2(blk * blk) : 1;
    endfunction
endpackage

// File: rtl/sasa_round.sv
// sasa_round: registered round-half-up and prune stage for CAM1 results
module sasa_round #(
    parameter int DATA_W   = 32,
    parameter int FRAC     = 4,
    parameter int PRUNE_TH = -100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x_valid,
    input  logic [DATA_W-1:0] x,
    output logic              y_valid,
    output logic [DATA_W-1:0] y,
    output logic              pruned
);
    localparam logic [DATA_W:0] HALF = FRAC > 0 ? (DATA_W+1)'(1) << (FRAC > 0 ? FRAC - 1 : 0) : '0;
    logic [DATA_W:0] sum;
    logic below;
    assign below = $signed(x) < PRUNE_TH;
    assign sum = {x[DATA_W-1], x} + HALF;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_valid <= 1'b0;
            y       <= '0;
            pruned  <= 1'b0;
        end else begin
            y_valid <= x_valid;
            y       <= x_valid && !below ? DATA_W'($signed(sum) >>> FRAC) : '0;
            pruned  <= x_valid && below;
        end
    end
endmodule

// File: rtl/sasa_block_engine.sv
// sasa_block_engine: fetches diagonal score tiles and sequences CAM1 find-max, subtract and rounding per block
module sasa_block_engine
    import sasa_pkg::*;
#(
    parameter int DATA_W   = SASA_DATA_W,
    parameter int BLK      = SASA_BLK,
    parameter int MAX_NBLK = SASA_MAX_NBLK,
    parameter int ADDR_W   = SASA_ADDR_W,
    parameter int FRAC     = SASA_FRAC,
    parameter int PRUNE_TH = SASA_PRUNE_TH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [$clog2(MAX_NBLK+1)-1:0]  cfg_nblk,
    output logic                           mem_req,
    output logic [ADDR_W-1:0]              mem_addr_x,
    output logic [ADDR_W-1:0]              mem_addr_y,
    input  logic                           mem_valid,
    input  logic [DATA_W-1:0]              mem_data,
    output logic                           cam_wr_valid,
    output logic [DATA_W-1:0]              cam_wr_data,
    input  logic                           cam_match_valid,
    input  logic [BLK*BLK-1:0]             cam_match,
    output logic                           sub_valid,
    output logic [BLK*BLK-1:0]             sub_match,
    input  logic                           cam1_valid,
    input  logic [DATA_W-1:0]              cam1_out,
    output logic                           round_valid,
    output logic [DATA_W-1:0]              round_data,
    output logic                           round_pruned,
    input  logic                           cam2_done,
    output logic                           busy,
    output logic                           finish,
    output logic                           err_nomatch
);
    localparam int N  = BLK * BLK;
    localparam int IW = tile_idx_w(BLK);
    localparam int NW = $clog2(MAX_NBLK + 1);
    sasa_state_e state, state_nx;
    logic [NW-1:0] nblk, cnt;
    logic [ADDR_W-1:0] pivot;
    logic [IW-1:0] k;
    logic [DATA_W-1:0] tile [N];
    logic last_k, idle_start, step_k, norm_acc;
    assign last_k     = k == IW'(N - 1);
    assign idle_start = (state == IDLE || state == DONE) && start;
    assign norm_acc   = state == NORM && cam1_valid;
    assign step_k     = (state == LOAD && mem_valid) || state == FMAX || norm_acc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx     = state;
        mem_req      = state == LOAD;
        mem_addr_x   = pivot + ADDR_W'(k % BLK);
        mem_addr_y   = pivot + ADDR_W'(k / BLK);
        cam_wr_valid = state == FMAX;
        cam_wr_data  = state == FMAX ? tile[k] : '0;
        sub_valid    = state == SUB;
        busy         = state != IDLE && state != DONE;
        finish       = state == DONE;
        case (state)
            IDLE, DONE: if (start) state_nx = cfg_nblk == '0 ? DONE : LOAD;
            LOAD:       if (mem_valid && last_k) state_nx = FMAX;
            FMAX:       if (last_k) state_nx = MWAIT;
            MWAIT:      if (cam_match_valid) state_nx = SUB;
            SUB:        state_nx = NORM;
            NORM:       if (cam1_valid && last_k) state_nx = WB;
            WB:         if (cam2_done) state_nx = cnt + 1'b1 == nblk ? DONE : LOAD;
            default:    state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nblk        <= '0;
            cnt         <= '0;
            pivot       <= '0;
            k           <= '0;
            sub_match   <= '0;
            err_nomatch <= 1'b0;
        end else begin
            if (idle_start) begin
                nblk        <= cfg_nblk;
                cnt         <= '0;
                pivot       <= '0;
                k           <= '0;
                err_nomatch <= 1'b0;
            end
            if (step_k) k <= last_k ? '0 : k + 1'b1;
            // an empty max vector still needs one subtract lane, so fall back to lane 0
            if (state == MWAIT && cam_match_valid) begin
                sub_match <= cam_match == '0 ? N'(1) : cam_match;
                if (cam_match == '0) err_nomatch <= 1'b1;
            end
            if (state == WB && cam2_done) begin
                cnt   <= cnt + 1'b1;
                pivot <= pivot + ADDR_W'(BLK);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (state == LOAD && mem_valid) tile[k] <= mem_data;
    end
    sasa_round #(.DATA_W(DATA_W), .FRAC(FRAC), .PRUNE_TH(PRUNE_TH)) u_round (
        .clk     (clk),
        .reset   (reset),
        .x_valid (norm_acc),
        .x       (cam1_out),
        .y_valid (round_valid),
        .y       (round_data),
        .pruned  (round_pruned)
    );
endmodule

// File: tb/tb_sasa_block_engine.sv
// tb_sasa_block_engine: directed table-driven checks of the SASA block engine
module tb_sasa_block_engine;
    logic clk = 1'b0;
    logic reset, start, mem_req, mem_valid, mem_en, cam_wr_valid, cam_match_valid;
    logic sub_valid, cam1_valid, round_valid, round_pruned, cam2_done, busy, finish, err_nomatch;
    logic [3:0] cfg_nblk;
    logic [5:0] mem_addr_x, mem_addr_y;
    logic [31:0] mem_data, cam_wr_data, cam1_out, round_data;
    logic [15:0] cam_match, sub_match;
    int n_cmp = 0, n_err = 0;
    logic err_exp = 1'b0;
    typedef struct {logic [31:0] x; logic [31:0] y; logic p;} rvec_t;
    rvec_t tv [16];
    always #5 clk = ~clk;
    // memory answers every cycle regardless of mem_req unless stalled
    assign mem_valid = mem_en;
    assign mem_data  = 32'(16 * mem_addr_y + mem_addr_x);
    sasa_block_engine dut (
        .clk(clk), .reset(reset), .start(start), .cfg_nblk(cfg_nblk),
        .mem_req(mem_req), .mem_addr_x(mem_addr_x), .mem_addr_y(mem_addr_y),
        .mem_valid(mem_valid), .mem_data(mem_data),
        .cam_wr_valid(cam_wr_valid), .cam_wr_data(cam_wr_data),
        .cam_match_valid(cam_match_valid), .cam_match(cam_match),
        .sub_valid(sub_valid), .sub_match(sub_match),
        .cam1_valid(cam1_valid), .cam1_out(cam1_out),
        .round_valid(round_valid), .round_data(round_data), .round_pruned(round_pruned),
        .cam2_done(cam2_done), .busy(busy), .finish(finish), .err_nomatch(err_nomatch)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic do_block(input int piv, input logic [15:0] m, input int stall_at, input int wb_wait);
        chk("load_req", mem_req, 1);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                mem_en = 1'b0;
                start = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_x", mem_addr_x, piv + i % 4);
                    chk("stall_y", mem_addr_y, piv + i / 4);
                end
                mem_en = 1'b1;
                start = 1'b0;
                chk("start_ignored", busy, 1);
            end
            chk("addr_x", mem_addr_x, piv + i % 4);
            chk("addr_y", mem_addr_y, piv + i / 4);
            @(negedge clk);
        end
        for (int j = 0; j < 16; j++) begin
            chk("fmax_valid", cam_wr_valid, 1);
            chk("fmax_data", cam_wr_data, 16 * (piv + j / 4) + piv + j % 4);
            @(negedge clk);
        end
        chk("fmax_len", cam_wr_valid, 0);
        cam_match_valid = 1'b1;
        cam_match = m;
        cam1_valid = 1'b1;
        cam1_out = 32'd24;
        cam2_done = 1'b1;
        if (m == 16'h0) err_exp = 1'b1;
        @(negedge clk);
        cam_match_valid = 1'b0;
        cam1_valid = 1'b0;
        cam2_done = 1'b0;
        chk("sub_valid", sub_valid, 1);
        chk("sub_match", sub_match, m == 16'h0 ? 64'd1 : 64'(m));
        chk("err_nomatch", err_nomatch, err_exp);
        chk("cam1_ignored", round_valid, 0);
        @(negedge clk);
        chk("sub_pulse", sub_valid, 0);
        for (int i = 0; i < 16; i++) begin
            cam1_valid = 1'b1;
            cam1_out = tv[i].x;
            @(negedge clk);
            chk("round_valid", round_valid, 1);
            chk("round_data", round_data, tv[i].y);
            chk("round_pruned", round_pruned, tv[i].p);
        end
        cam1_valid = 1'b0;
        for (int w = 0; w < wb_wait; w++) begin
            @(negedge clk);
            chk("wb_wait_busy", busy, 1);
            chk("wb_round_idle", round_valid, 0);
        end
        cam2_done = 1'b1;
        @(negedge clk);
        cam2_done = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        tv[0]  = '{32'd24, 32'd2, 1'b0};
        tv[1]  = '{32'd23, 32'd1, 1'b0};
        tv[2]  = '{-32'sd100, -32'sd6, 1'b0};
        tv[3]  = '{-32'sd101, 32'd0, 1'b1};
        tv[4]  = '{-32'sd8, 32'd0, 1'b0};
        tv[5]  = '{32'd7, 32'd0, 1'b0};
        tv[6]  = '{32'd8, 32'd1, 1'b0};
        tv[7]  = '{-32'sd9, -32'sd1, 1'b0};
        tv[8]  = '{-32'sd24, -32'sd1, 1'b0};
        tv[9]  = '{-32'sd25, -32'sd2, 1'b0};
        tv[10] = '{32'd0, 32'd0, 1'b0};
        tv[11] = '{32'h7fffffff, 32'h08000000, 1'b0};
        tv[12] = '{32'h80000000, 32'd0, 1'b1};
        tv[13] = '{-32'sd99, -32'sd6, 1'b0};
        tv[14] = '{32'd100, 32'd6, 1'b0};
        tv[15] = '{-32'sd1000, 32'd0, 1'b1};
        reset = 1'b1;
        start = 1'b0;
        cfg_nblk = 4'd0;
        mem_en = 1'b1;
        cam_match_valid = 1'b0;
        cam_match = 16'h0;
        cam1_valid = 1'b0;
        cam1_out = 32'd0;
        cam2_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_addr", {mem_addr_x, mem_addr_y}, 0);
        chk("rst_sub_match", sub_match, 0);
        chk("rst_round_valid", round_valid, 0);
        chk("rst_err", err_nomatch, 0);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cfg_nblk = 4'd1;
        @(negedge clk);
        start = 1'b0;
        do_block(0, 16'h0020, -1, 0);
        chk("single_finish", finish, 1);
        chk("single_busy", busy, 0);
        start = 1'b1;
        cfg_nblk = 4'd3;
        err_exp = 1'b0;
        @(negedge clk);
        start = 1'b0;
        do_block(0, 16'h0000, 6, 0);
        chk("blk1_not_done", finish, 0);
        do_block(4, 16'h8001, -1, 2);
        chk("blk2_not_done", finish, 0);
        do_block(8, 16'h0100, -1, 1);
        chk("blk3_finish", finish, 1);
        chk("err_sticky", err_nomatch, 1);
        start = 1'b1;
        cfg_nblk = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_finish", finish, 1);
        chk("zero_mem_req", mem_req, 0);
        chk("err_cleared", err_nomatch, 0);
        start = 1'b1;
        cfg_nblk = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        cam_match_valid = 1'b1;
        cam_match = 16'h0004;
        @(negedge clk);
        cam_match_valid = 1'b0;
        @(negedge clk);
        cam1_valid = 1'b1;
        cam1_out = 32'd24;
        @(negedge clk);
        chk("pre_rst_round", round_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_round_valid", round_valid, 0);
        chk("mid_rst_round_data", round_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sub_match", sub_match, 0);
        chk("mid_rst_outs", {finish, mem_req, sub_valid, cam_wr_valid, err_nomatch}, 0);
        cam1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_finish", finish, 0);
        start = 1'b1;
        cfg_nblk = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("idle_zero_finish", finish, 1);
        chk("idle_zero_req", mem_req, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
